// File: rtl/button_event_decoder.sv
// Classifies debounced button activity into short, long and double press events.
// State encodings and register reset values are all-zero so power-up matches reset.
module button_event_decoder #(
    parameter int unsigned CLK_FREQ_HZ   = 10_000_000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned DOUBLE_GAP_MS = 300,
    parameter bit          IS_PULLUP     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_level,
    input  logic       btn_valid,
    output logic       event_valid,
    output logic [1:0] event_code,
    output logic       busy
);

    localparam int unsigned DIV = CLK_FREQ_HZ / 1000;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned MW  = 16;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [MW-1:0] MS_MAX     = '1;
    localparam logic [MW-1:0] LONG_LIM   = MW'(LONG_PRESS_MS);
    localparam logic [MW-1:0] GAP_LIM    = MW'(DOUBLE_GAP_MS);

    localparam logic [1:0] EV_NONE   = 2'b00;
    localparam logic [1:0] EV_SHORT  = 2'b01;
    localparam logic [1:0] EV_LONG   = 2'b10;
    localparam logic [1:0] EV_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_GAP    = 3'd2,
        S_PRESS2 = 3'd3,
        S_HELD   = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [MW-1:0]   ms_q, ms_d;
    logic            ev_valid_q, ev_valid_d;
    logic [1:0]      ev_code_q, ev_code_d;
    logic            busy_q, busy_d;

    logic            pressed_c;
    logic            press_edge_c;
    logic            release_edge_c;
    logic            tick_c;
    logic            timeout_c;
    logic [MW-1:0]   limit_c;

    // Edge classification against the configured pressed polarity
    always_comb begin
        pressed_c      = btn_level ^ IS_PULLUP;
        press_edge_c   = btn_valid & pressed_c;
        release_edge_c = btn_valid & ~pressed_c;
        tick_c         = (presc_q == PRESC_LAST);
    end

    // Active timeout limit; only the timed states can time out
    always_comb begin
        limit_c   = LONG_LIM;
        timeout_c = 1'b0;
        case (state_q)
            S_PRESS1, S_PRESS2: begin
                limit_c   = LONG_LIM;
                timeout_c = (ms_q == LONG_LIM);
            end
            S_GAP: begin
                limit_c   = GAP_LIM;
                timeout_c = (ms_q == GAP_LIM);
            end
            default: begin
                limit_c   = LONG_LIM;
                timeout_c = 1'b0;
            end
        endcase
    end

    // Next-state and event decode; edges are checked before timeouts so they win
    always_comb begin
        state_d    = state_q;
        ev_valid_d = 1'b0;
        ev_code_d  = EV_NONE;
        case (state_q)
            S_IDLE: begin
                if (press_edge_c) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (release_edge_c) begin
                    state_d = S_GAP;
                end else if (timeout_c) begin
                    state_d    = S_HELD;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_LONG;
                end
            end
            S_GAP: begin
                if (press_edge_c) begin
                    state_d = S_PRESS2;
                end else if (timeout_c) begin
                    state_d    = S_IDLE;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_SHORT;
                end
            end
            S_PRESS2: begin
                if (release_edge_c) begin
                    state_d    = S_IDLE;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_DOUBLE;
                end else if (timeout_c) begin
                    state_d    = S_HELD;
                    ev_valid_d = 1'b1;
                    ev_code_d  = EV_LONG;
                end
            end
            S_HELD: begin
                if (release_edge_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Millisecond timebase restarts on every state change
    always_comb begin
        presc_d = presc_q;
        ms_d    = ms_q;
        busy_d  = (state_d != S_IDLE);
        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end else begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
            if (tick_c && (ms_q != MS_MAX)) begin
                ms_d = ms_q + MW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            ms_q       <= '0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= EV_NONE;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ms_q       <= ms_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            busy_q     <= busy_d;
        end
    end

    assign event_valid = ev_valid_q;
    assign event_code  = ev_code_q;
    assign busy        = busy_q;

endmodule
